lsu_handshake_stage: RTL and testbench
======================================

# lsu_handshake_stage

Parametrised load/store unit that replaces the single-cycle memory-stage glue between the execute/memory pipeline register and the data-memory bus. It generates byte-lane masks and lane-aligned store data for SB/SH/SW, sign- or zero-extends LB/LH/LW/LBU/LHU results, and runs a request/valid/data_valid handshake FSM. The FSM stalls the pipeline until the access completes, checks alignment, and enforces a bus timeout.

## Interface
- ADDR_W, 32, width of address in and out
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before abort; minimum 2
- MISALIGN_TRAP, 1, 1 = misaligned access raises `misalign` and no bus access; 0 = low address bits forced to 0 and access issued
- Data width is fixed at 32 bits, 4 byte lanes.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- load, store  in  1 each  access request from the MEM pipeline register; never both high
- funct3  in  3  RV32I width/sign code
- addr  in  ADDR_W  effective address (ALU result)
- store_data  in  32  rs2 value
- request  out  1  bus request
- we_re  out  1  1 = write
- mask  out  4  byte enables
- addr_out  out  ADDR_W  word-aligned address, low 2 bits zero
- wdata  out  32  lane-aligned store data
- valid  in  1  bus accepted the request
- data_valid  in  1  read data present on `rdata`
- rdata  in  32  read word
- stall  out  1  hold IF/ID/EX/MEM pipeline registers
- load_data  out  32  extended load result, held until the next load completes
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle alignment fault pulse
- bus_timeout  out  1  one-cycle timeout pulse

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `load|store` and the access is aligned, latch `addr_out`, `mask`, `wdata`, `we_re`, funct3 and `addr[1:0]`, then go to REQ.
  - If the access is misaligned and MISALIGN_TRAP=1, pulse `misalign` next cycle, issue no request and stay in IDLE.
- **REQ:** `request` is 1. Latched outputs stay stable until `valid`.
  - On `valid` with a store, go to DONE.
  - On `valid` with a load, go to WAIT. If `data_valid` is also high in that cycle, capture `rdata` and go directly to DONE.
- **WAIT:** on `data_valid`, capture extended `rdata` into `load_data` and go to DONE.
- **DONE:** `done`=1 and `stall`=0, so the pipeline advances this edge. `load|store` inputs are ignored in DONE. Next state is IDLE.
- **Alignment:**
  - Halfword accesses require `addr[0]`=0.
  - Word accesses require `addr[1:0]`=0.
  - Byte accesses are always aligned.
- **Masks:**
  - SB: `4'b0001 << addr[1:0]`
  - SH: `4'b0011 << addr[1:0]`
  - SW: `4'b1111`
  - Loads drive `4'b1111`.
- **wdata:** SB replicates byte[7:0] into all four lanes. SH replicates half[15:0] into both halves. SW passes the word through.
- **Load extend:** select the lane using the latched `addr[1:0]`. funct3 000/001 sign-extend, 100/101 zero-extend, 010 passes the word through. Other funct3 codes return 0.
- **Timeout counter:**
  - Cleared on entry to REQ and counts each cycle in REQ or WAIT.
  - At TIMEOUT_CYCLES: drop `request`, pulse `bus_timeout`, go to DONE, and do not update `load_data`.
- **Reset** (async, any state): state=IDLE. All outputs are 0, including `load_data` and `mask`. `request` drops immediately, with no completion.

## Timing
- `stall` is combinational: `(IDLE & (load|store) & aligned) | REQ | WAIT`.
- **Latency:**
  - Store with `valid` in the first REQ cycle: 3 cycles from `load|store` to `done` (IDLE, REQ, DONE).
  - Load with same-cycle `valid`+`data_valid`: 3 cycles.
  - Each cycle waiting for `valid` or `data_valid` adds 1.
- `load_data` updates on the edge entering DONE and is valid while `done`=1.
- `done`, `misalign` and `bus_timeout` are registered, mutually exclusive, and one cycle each.
- `data_valid` is ignored outside REQ/WAIT.

## Structure
- A shared package `lsu_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/DONE)
  - funct3 constants F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW
- One combinational sub-module `lsu_align` holds the mask and wdata generation, the alignment check and the load extender. The FSM, latches and counter live in the top.

## Test plan
- **SB:** addr=0x1003, store_data=0x000000A5, `valid` in first REQ cycle -> `mask`=4'b1000, `wdata`=0xA5A5A5A5, `addr_out`=0x1000, `we_re`=1, `done` at cycle 3, `stall` high for 2 cycles.
- **LH:** addr=0x2002, rdata=0x80FF1234, `data_valid` 2 cycles after `valid` -> `load_data`=0xFFFF80FF. LHU on the same access -> 0x000080FF. `stall` high for 4 cycles.
- **Misaligned LW:** addr=0x3001, MISALIGN_TRAP=1 -> `misalign` pulses once, `request` never rises, `stall` stays 0.
- **Timeout:** load, `valid` never asserted, TIMEOUT_CYCLES=4 -> `request` high for 4 cycles, `bus_timeout` pulses, `load_data` keeps its previous value.
- **Reset mid-WAIT:** `rst` low during WAIT -> `request`, `stall` and `load_data` go to 0 immediately. After release, a fresh LW (rdata=0xDEADBEEF) completes normally.
- **Back-to-back:** SW then LBU, each `valid` immediate -> two `done` pulses 3 cycles apart. The LBU returns the zero-extended lane byte.

Source files
------------

// File: rtl/lsu_handshake_stage_pkg.sv
// Shared types and RV32I funct3 codes for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_handshake_stage_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_handshake_stage_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              request;
  logic              we_re;
  logic [3:0]        mask;
  logic [ADDR_W-1:0] addr_out;
  logic [31:0]       wdata;
  logic              valid;
  logic              data_valid;
  logic [31:0]       rdata;

  modport master (
    output request, we_re, mask, addr_out, wdata,
    input  valid, data_valid, rdata
  );

  modport slave (
    input  request, we_re, mask, addr_out, wdata,
    output valid, data_valid, rdata
  );
endinterface

// File: rtl/lsu_handshake_stage_align.sv
// Byte-lane logic: alignment check, store mask/data replication, load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_store,
  input  logic [31:0] store_data,
  output logic        aligned,
  output logic [1:0]  off_eff,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // off_eff clears the offending low bits so a non-trapping build still issues a sane access
  always_comb begin
    aligned = 1'b1;
    off_eff = off;
    mask    = 4'b1111;
    wdata   = store_data;
    case (size)
      2'b00: begin
        if (is_store) mask = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned = ~off[0];
        off_eff = {off[1], 1'b0};
        if (is_store) mask = 4'b0011 << off_eff;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        aligned = (off == 2'b00);
        off_eff = '0;
      end
    endcase
  end

  always_comb begin
    lane8  = rdata[{ld_off, 3'b000} +: 8];
    lane16 = rdata[{ld_off[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_LB:   load_ext = {{24{lane8[7]}}, lane8};
      F3_LH:   load_ext = {{16{lane16[15]}}, lane16};
      F3_LW:   load_ext = rdata;
      F3_LBU:  load_ext = {24'd0, lane8};
      F3_LHU:  load_ext = {16'd0, lane16};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_handshake_stage.sv
// Memory-stage load/store unit: latches the access, runs the bus handshake
// with timeout, and stalls the pipeline until completion.
module lsu_handshake_stage
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          MISALIGN_TRAP  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    store,
  input  logic [2:0]              funct3,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [31:0]             store_data,
  lsu_handshake_stage_if.master   bus,
  output logic                    stall,
  output logic [31:0]             load_data,
  output logic                    done,
  output logic                    misalign,
  output logic                    bus_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q, mask_c;
  logic [31:0]       wdata_q, wdata_c, load_ext;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q, off_eff;
  logic              aligned, cnt_last;
  logic              accept, trap, capture, finish, expire;

  lsu_align u_align (
    .size      (funct3[1:0]),
    .off       (addr[1:0]),
    .is_store  (store),
    .store_data(store_data),
    .aligned   (aligned),
    .off_eff   (off_eff),
    .mask      (mask_c),
    .wdata     (wdata_c),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (bus.rdata),
    .load_ext  (load_ext)
  );

  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A completing response in the final counted cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    trap    = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load || store) begin
          if (aligned || !MISALIGN_TRAP) begin
            accept  = 1'b1;
            state_d = ST_REQ;
          end else begin
            trap = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus.valid && (we_q || bus.data_valid)) begin
          finish  = 1'b1;
          capture = ~we_q;
          state_d = ST_DONE;
        end else if (cnt_last) begin
          expire  = 1'b1;
          state_d = ST_DONE;
        end else if (bus.valid) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.data_valid) begin
          finish  = 1'b1;
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_last) begin
          expire  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      load_data   <= '0;
      done        <= 1'b0;
      misalign    <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      done        <= finish;
      misalign    <= trap;
      bus_timeout <= expire;
      if (accept) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        mask_q  <= mask_c;
        wdata_q <= wdata_c;
        we_q    <= store;
        f3_q    <= funct3;
        off_q   <= off_eff;
        cnt_q   <= '0;
      end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) load_data <= load_ext;
    end
  end

  assign stall        = accept || state_q == ST_REQ || state_q == ST_WAIT;
  assign bus.request  = (state_q == ST_REQ);
  assign bus.we_re    = we_q;
  assign bus.mask     = mask_q;
  assign bus.addr_out = addr_q;
  assign bus.wdata    = wdata_q;

endmodule

// File: tb/tb_lsu_handshake_stage.sv
// Self-checking bench for lsu_handshake_stage: directed table, hand sequences, random accesses.
module tb_lsu_handshake_stage;
  import lsu_pkg::*;

  localparam int T = 4;

  logic        clk, rst, load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, done, misalign, bus_timeout;
  int          checks, failures;
  logic [31:0] prev_ld;

  lsu_handshake_stage_if #(.ADDR_W(32)) bus ();

  lsu_handshake_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(T), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .bus(bus), .stall(stall), .load_data(load_data),
    .done(done), .misalign(misalign), .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd;
    int          vdel, dvdel;
    logic [3:0]  emask;
    logic [31:0] ewdata, eao, eld;
    int          estall, ereq, ekind;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the access rules (kind 0=done 1=misalign 2=timeout)
  function automatic vec_t model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd,
                                 input int vdel, input int dvdel, input logic [31:0] prev);
    vec_t r;
    int size, nbytes, off, busn;
    bit ok, timed;
    logic [31:0] lane, v;
    r.st = st; r.f3 = f3; r.a = a; r.sd = sd; r.rd = rd; r.vdel = vdel; r.dvdel = dvdel;
    size   = (f3[1:0] == 2'd3) ? 2 : int'(f3[1:0]);
    nbytes = 1 << size;
    off    = int'(a % 4);
    ok     = (off % nbytes) == 0;
    r.emask  = st ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
    r.ewdata = (size == 0) ? sd[7:0] * 32'h01010101 : (size == 1) ? sd[15:0] * 32'h00010001 : sd;
    r.eao    = a - 32'(off);
    r.eld    = prev;
    if (!ok) begin
      r.ekind = 1; r.estall = 0; r.ereq = 0;
      return r;
    end
    busn  = st ? vdel + 1 : vdel + 1 + dvdel;
    timed = (vdel < 0) || (!st && dvdel < 0) || (busn > T);
    r.ekind  = timed ? 2 : 0;
    r.estall = 1 + (timed ? T : busn);
    r.ereq   = (vdel < 0) ? T : ((vdel + 1 > T) ? T : vdel + 1);
    if (!timed && !st) begin
      lane = rd >> (8 * off);
      case (f3)
        3'b000: begin v = lane & 32'hFF;   if (v >= 128)   v = v - 256;   end
        3'b001: begin v = lane & 32'hFFFF; if (v >= 32768) v = v - 65536; end
        3'b010: v = rd;
        3'b100: v = lane & 32'hFF;
        3'b101: v = lane & 32'hFFFF;
        default: v = 0;
      endcase
      r.eld = v;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input string name);
    int stall_n, req_n, req_seen, since_v, kind, pcyc;
    logic [3:0]  m;
    logic [31:0] wd, ao, ld;
    logic        we;
    stall_n = 0; req_n = 0; req_seen = 0; since_v = -1; kind = -1; pcyc = 0;
    m = '0; wd = '0; ao = '0; ld = '0; we = 1'b0;
    @(posedge clk); #1;
    load = !v.st; store = v.st; funct3 = v.f3; addr = v.a; store_data = v.sd;
    for (int c = 1; c <= 20 && kind < 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        load = 1'b0; store = 1'b0;
      end
      bus.valid = 1'b0; bus.data_valid = 1'b0;
      if (bus.request) begin
        if (req_seen == v.vdel) begin
          bus.valid = 1'b1; since_v = 0;
          if (!v.st && v.dvdel == 0) bus.data_valid = 1'b1;
        end
        req_seen++;
      end else if (since_v >= 0) begin
        since_v++;
        if (since_v == v.dvdel) bus.data_valid = 1'b1;
      end
      bus.rdata = bus.data_valid ? v.rd : $urandom;
      @(negedge clk);
      if (stall) stall_n++;
      if (bus.request) begin
        req_n++; m = bus.mask; wd = bus.wdata; ao = bus.addr_out; we = bus.we_re;
      end
      if (done || misalign || bus_timeout) begin
        kind = done ? 0 : misalign ? 1 : 2;
        if (int'(done) + int'(misalign) + int'(bus_timeout) > 1) kind = 7;
        pcyc = c; ld = load_data;
      end
    end
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.data_valid = 1'b0;
    @(negedge clk);
    check({name, ".kind"}, 32'(kind), 32'(v.ekind));
    check({name, ".pulse_cycle"}, 32'(pcyc), 32'((v.ekind == 1) ? 2 : v.estall + 1));
    check({name, ".stall_cycles"}, 32'(stall_n), 32'(v.estall));
    check({name, ".request_cycles"}, 32'(req_n), 32'(v.ereq));
    check({name, ".load_data"}, ld, v.eld);
    check({name, ".quiet_after"}, {27'd0, done, misalign, bus_timeout, bus.request, stall}, 32'd0);
    if (v.ereq > 0) begin
      check({name, ".addr_out"}, ao, v.eao);
      check({name, ".we_re"}, 32'(we), 32'(v.st));
      check({name, ".mask"}, 32'(m), 32'(v.emask));
      if (v.st) check({name, ".wdata"}, wd, v.ewdata);
    end
  endtask

  vec_t tbl[7];
  vec_t v;
  int   dc[$];

  initial begin
    checks = 0; failures = 0;
    tbl[0] = '{1, F3_SB,  32'h1003, 32'hA5,       32'h0,        0,  0, 4'b1000, 32'hA5A5A5A5, 32'h1000, 32'h0,        2, 1, 0};
    tbl[1] = '{0, F3_LH,  32'h2002, 32'h0,        32'h80FF1234, 0,  2, 4'hF,    32'h0,        32'h2000, 32'hFFFF80FF, 4, 1, 0};
    tbl[2] = '{0, F3_LHU, 32'h2002, 32'h0,        32'h80FF1234, 0,  2, 4'hF,    32'h0,        32'h2000, 32'h000080FF, 4, 1, 0};
    tbl[3] = '{0, F3_LW,  32'h3001, 32'h0,        32'h12345678, 0,  0, 4'hF,    32'h0,        32'h3000, 32'h000080FF, 0, 0, 1};
    tbl[4] = '{0, F3_LW,  32'h3000, 32'h0,        32'h12345678, -1, 0, 4'hF,    32'h0,        32'h3000, 32'h000080FF, 5, 4, 2};
    tbl[5] = '{1, F3_SH,  32'h0006, 32'h1234BEEF, 32'h0,        1,  0, 4'b1100, 32'hBEEFBEEF, 32'h4,    32'h000080FF, 3, 2, 0};
    tbl[6] = '{0, F3_LB,  32'h0005, 32'h0,        32'h12348056, 0,  1, 4'hF,    32'h0,        32'h4,    32'hFFFFFF80, 3, 1, 0};

    rst = 1'b0; load = 1'b0; store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    bus.valid = 1'b0; bus.data_valid = 1'b0; bus.rdata = '0;
    #12;
    check("reset.outputs", {25'd0, bus.request, bus.we_re, stall, done, misalign, bus_timeout, 1'b0}, 32'd0);
    check("reset.load_data", load_data, 32'd0);
    check("reset.mask", 32'(bus.mask), 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      prev_ld = tbl[i].eld;
    end

    // Reset asserted while waiting for read data
    @(posedge clk); #1;
    load = 1'b1; funct3 = F3_LH; addr = 32'h2002;
    @(posedge clk); #1;
    load = 1'b0; bus.valid = 1'b1; bus.data_valid = 1'b0;
    @(negedge clk);
    check("rstwait.request_in_req", 32'(bus.request), 32'd1);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    @(negedge clk);
    check("rstwait.stall_in_wait", 32'(stall), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rstwait.async_clear", {29'd0, bus.request, stall, done}, 32'd0);
    check("rstwait.load_data", load_data, 32'd0);
    @(negedge clk); rst = 1'b1;
    prev_ld = 32'd0;
    v = model(1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, prev_ld);
    apply(v, "post_reset_lw");
    prev_ld = v.eld;

    // SW then LBU held through the SW's DONE cycle; the held request must be ignored there
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      store = (c == 1);
      load  = (c == 3 || c == 4);
      funct3 = (c == 1) ? F3_SW : F3_LBU;
      addr   = (c == 1) ? 32'h40 : 32'h41;
      store_data = 32'hCAFEF00D;
      bus.valid = bus.request;
      bus.data_valid = bus.request && !bus.we_re;
      bus.rdata = 32'h11223344;
      @(negedge clk);
      if (done) dc.push_back(c);
    end
    load = 1'b0; bus.valid = 1'b0; bus.data_valid = 1'b0;
    check("b2b.done_count", 32'(dc.size()), 32'd2);
    check("b2b.first_done", 32'((dc.size() > 0) ? dc[0] : 0), 32'd3);
    check("b2b.second_done", 32'((dc.size() > 1) ? dc[1] : 0), 32'd6);
    check("b2b.lbu_data", load_data, 32'h00000033);
    prev_ld = 32'h00000033;

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  lf [7];
      logic [2:0]  f3;
      logic [31:0] a;
      bit          st;
      int          vd, dd;
      lf = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, 3'b011, 3'b110};
      st = 1'($urandom_range(0, 1));
      if (st) f3 = 3'($urandom_range(0, 2));
      else    f3 = lf[$urandom_range(0, 6)];
      a = $urandom;
      if ($urandom_range(0, 5) == 0) vd = -1; else vd = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) dd = -1; else dd = int'($urandom_range(0, 1));
      v = model(st, f3, a, $urandom, $urandom, vd, dd, prev_ld);
      apply(v, $sformatf("rand%0d", i));
      prev_ld = v.eld;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
